// File: rtl/otn_demapper.sv
// otn_demapper: FAS hunt/presync/sync framer with payload extraction, CRC-8 check and ARQ ack
module otn_demapper #(
  parameter int         PYLD_LEN    = 32,
  parameter logic [7:0] FAS0        = 8'hF6,
  parameter logic [7:0] FAS1        = 8'h28,
  parameter int         SYNC_FRAMES = 2,
  parameter int         LOSS_FRAMES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  input  logic       i_arq_en,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  output logic       o_frame_done,
  output logic       o_crc_ok,
  output logic       o_ack,
  output logic       o_lock,
  output logic [7:0] o_crc_err_cnt
);
  localparam int         L  = PYLD_LEN + 3;
  localparam int         PW = $clog2(L);
  localparam logic [7:0] SF = 8'(SYNC_FRAMES);
  localparam logic [7:0] LF = 8'(LOSS_FRAMES);
  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;
  state_t        state_q;
  logic [PW-1:0] pos_q;
  logic [7:0]    prev_q, good_q, miss_q, crc_q, crc_d;
  logic          fas_hit, at_fas1, is_pay, is_crc, crc_good;
  assign fas_hit  = prev_q == FAS0 && i_frame_data == FAS1;
  assign at_fas1  = pos_q == PW'(1);
  assign is_pay   = pos_q >= PW'(2) && pos_q <= PW'(PYLD_LEN + 1);
  assign is_crc   = pos_q == PW'(L - 1);
  assign crc_good = crc_q == i_frame_data;
  // bytewise CRC-8 (poly 0x07, MSB first) of the accumulator with the incoming byte
  always_comb begin
    crc_d = crc_q ^ i_frame_data;
    for (int b = 0; b < 8; b++) crc_d = crc_d[7] ? {crc_d[6:0], 1'b0} ^ 8'h07 : {crc_d[6:0], 1'b0};
  end
  // framing FSM, position/CRC tracking and registered client/ack outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q           <= HUNT;
      pos_q             <= '0;
      prev_q            <= '0;
      good_q            <= '0;
      miss_q            <= '0;
      crc_q             <= '0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_frame_done      <= 1'b0;
      o_crc_ok          <= 1'b0;
      o_ack             <= 1'b0;
      o_lock            <= 1'b0;
      o_crc_err_cnt     <= '0;
    end else begin
      o_pyld_data_valid <= 1'b0;
      o_frame_done      <= 1'b0;
      o_ack             <= 1'b0;
      if (i_frame_data_valid) begin
        prev_q <= i_frame_data;
        pos_q  <= is_crc ? '0 : pos_q + 1'b1;
        crc_q  <= is_pay ? crc_d : '0;
        case (state_q)
          HUNT: if (fas_hit) begin
            pos_q   <= PW'(2);
            crc_q   <= '0;
            good_q  <= 8'd1;
            miss_q  <= '0;
            state_q <= SF == 8'd1 ? SYNC : PRESYNC;
            o_lock  <= SF == 8'd1;
          end
          PRESYNC: if (at_fas1) begin
            good_q  <= good_q + 8'd1;
            state_q <= !fas_hit ? HUNT : (good_q + 8'd1 >= SF ? SYNC : PRESYNC);
            o_lock  <= fas_hit && good_q + 8'd1 >= SF;
            miss_q  <= '0;
          end
          SYNC: if (at_fas1) begin
            miss_q  <= fas_hit ? '0 : miss_q + 8'd1;
            state_q <= !fas_hit && miss_q + 8'd1 >= LF ? HUNT : SYNC;
            o_lock  <= fas_hit || miss_q + 8'd1 < LF;
          end
          default: state_q <= HUNT;
        endcase
        if (o_lock && is_pay) begin
          o_pyld_data_valid <= 1'b1;
          o_pyld_data       <= i_frame_data;
        end
        if (o_lock && is_crc) begin
          o_frame_done <= 1'b1;
          o_crc_ok     <= crc_good;
          o_ack        <= crc_good && i_arq_en;
          if (!crc_good && o_crc_err_cnt != 8'hFF) o_crc_err_cnt <= o_crc_err_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: doc/otn_demapper.md
# otn_demapper

Receive-side frame demapper that consumes the byte stream recovered from the line and locates frame boundaries by searching for the frame alignment signal (FAS). Once aligned, it extracts payload bytes for the client, checks each frame's CRC-8 and pulses an acknowledge for every good frame. It is the downstream counterpart of the transmit mapper/tran_rec path. It feeds the client RX FIFO and the ARQ acknowledge return path.

## Interface
Parameters:
- PYLD_LEN, 32: payload bytes per frame (≥2).
- FAS0, 8'hF6: first FAS byte.
- FAS1, 8'h28: second FAS byte.
- SYNC_FRAMES, 2: consecutive correct FAS (including the hunt hit) needed to declare lock.
- LOSS_FRAMES, 3: consecutive FAS misses in SYNC that drop lock.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_frame_data  in  8  received line byte.
- i_frame_data_valid  in  1  i_frame_data is valid this cycle. The block never backpressures.
- i_arq_en  in  1  enables acknowledge generation.
- o_pyld_data  out  8  extracted payload byte.
- o_pyld_data_valid  out  1  o_pyld_data is valid. Not backpressured; the consumer must always accept it.
- o_frame_done  out  1  one-cycle pulse at the end of each frame emitted in SYNC.
- o_crc_ok  out  1  CRC result; qualified by o_frame_done.
- o_ack  out  1  one-cycle pulse on a good frame when i_arq_en=1.
- o_lock  out  1  high while the FSM is in SYNC.
- o_crc_err_cnt  out  8  saturating count of bad-CRC frames.

## Operation
- Frame layout, L = PYLD_LEN+3 bytes:
  - pos 0: FAS0.
  - pos 1: FAS1.
  - pos 2..PYLD_LEN+1: payload.
  - pos PYLD_LEN+2: CRC-8.
- Byte position counter `pos`, 0..L-1:
  - Advances only on i_frame_data_valid.
  - Wraps from L-1 to 0.
- `prev`: register holding the last valid byte.
- FSM states: HUNT, PRESYNC, SYNC. Reset state is HUNT.
- HUNT:
  - On a valid byte with prev==FAS0 and byte==FAS1: set pos=2 for the next byte and set good_cnt=1.
  - If SYNC_FRAMES==1, go to SYNC; otherwise go to PRESYNC.
  - `pos` is ignored while in HUNT.
- PRESYNC:
  - FAS is evaluated on the pos-1 byte, using the registered pos-0 byte.
  - Match: good_cnt++. When good_cnt reaches SYNC_FRAMES, go to SYNC.
  - Mismatch: go to HUNT. The same byte pair is not re-tested for a hunt hit.
- SYNC:
  - FAS match clears miss_cnt.
  - FAS mismatch increments miss_cnt. When miss_cnt reaches LOSS_FRAMES, go to HUNT and emit nothing further from that frame.
  - Otherwise the block flywheels: it keeps counting and emits the frame normally.
- Payload emission:
  - Payload of a frame is emitted only when the FSM is in SYNC after that frame's pos-1 evaluation. This includes the frame whose FAS declares lock.
  - Each payload byte appears on o_pyld_data with o_pyld_data_valid=1.
- CRC:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 8'h00, MSB-first, no reflection, no final XOR.
  - Computed over the payload bytes only.
  - The accumulator clears at pos 0.
  - At the CRC byte, o_crc_ok = (computed == received).
- Frame completion:
  - o_frame_done fires for every emitted frame.
  - o_ack = o_frame_done & o_crc_ok & i_arq_en, with i_arq_en sampled on the CRC-byte cycle.
  - On bad CRC, o_crc_err_cnt increments, saturating at 8'hFF.
- Reset values:
  - All outputs 0.
  - FSM in HUNT; pos, prev, good_cnt, miss_cnt and CRC accumulator cleared.
  - o_crc_err_cnt = 0.

## Timing
- All outputs are registered.
- o_pyld_data/_valid appear 1 cycle after the corresponding input byte is accepted.
- o_frame_done, o_crc_ok and o_ack appear 1 cycle after the CRC byte is accepted.
- o_lock and the FSM state change 1 cycle after the deciding FAS1 byte.
- Gaps in i_frame_data_valid stall all counters and produce no output. No timeout.
- Simultaneous lock loss and frame end cannot occur, because loss is decided at pos 1.
- Reset asserted mid-frame:
  - Outputs go to 0 on the next edge.
  - The partial frame is discarded.
  - The next frame requires a fresh hunt.
- A FAS pattern inside the payload during HUNT may cause a false hit. PRESYNC rejects it at the next pos-1 check.

## Test plan
- Reset, then 3 back-to-back frames with PYLD_LEN=32, payload 0x00..0x1F, correct CRC:
  - o_lock rises after the FAS of frame 2.
  - Frame 2 and frame 3 payloads are emitted in order.
  - 2 o_frame_done pulses with o_crc_ok=1.
  - 2 o_ack pulses with i_arq_en=1; 0 with i_arq_en=0.
- Locked stream, one frame's CRC byte XORed with 0x01:
  - That frame gives o_frame_done=1, o_crc_ok=0, no o_ack.
  - o_crc_err_cnt = 1.
  - The next frame is good.
- Locked stream, FAS0 corrupted in 2 consecutive frames, then correct: lock holds and both flywheel frames are emitted. Corrupted in 3 consecutive frames: o_lock falls after the third FAS1, and that frame emits no payload.
- HUNT with 0xF6,0x28 embedded in random bytes, not repeated at offset L: PRESYNC drops back to HUNT, and no payload or o_frame_done is produced.
- Random valid gaps (30% idle) over 10 good frames: payload bytes and CRC results are identical to the gap-free run.
- Assert i_rst_n=0 for 1 cycle at pos 15 of a locked frame:
  - All outputs are 0 next cycle.
  - Relock follows the normal SYNC_FRAMES sequence.
